// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared definitions for the writeback port arbiter.
//               - wb_sel mux codes
//               - FSM state enum
//               - requester index constants
//               - fixed-priority pick helper (MEM > MULDIV > ALU)
// Config      : none (WB_ARB_AGE_EN is consumed by wb_port_arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    // Select codes for the 32-bit 3-to-1 writeback mux.
    localparam logic [1:0] SEL_MEM  = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_MD   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Bit positions of each requester in the request/grant vectors.
    localparam int NUM_REQ = 3;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_MD  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // One-hot winner among the set bits of req, fixed order MEM > MD > ALU.
    function automatic logic [NUM_REQ-1:0] pick_fixed(input logic [NUM_REQ-1:0] req);
        logic [NUM_REQ-1:0] win;
        win = '0;
        if (req[REQ_MEM])      win[REQ_MEM] = 1'b1;
        else if (req[REQ_MD])  win[REQ_MD]  = 1'b1;
        else if (req[REQ_ALU]) win[REQ_ALU] = 1'b1;
        return win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_age_counter.sv
// ============================================================================
// Module      : wb_age_counter
// Description : Saturating wait counter for one writeback requester.
//               Counts cycles with req high and no grant; clears on grant or
//               when req is low. aged_o flags that the wait reached AGE_LIMIT.
// Ports       : Clk, Rst_n (async active-low)
//               req_i  - requester has a result pending
//               gnt_i  - requester is granted this cycle
//               aged_o - wait count >= AGE_LIMIT
// Config      : instantiated only when WB_ARB_AGE_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_age_counter #(
    parameter int AGE_LIMIT = 4,
    parameter int AGE_W     = 3
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic req_i,
    input  logic gnt_i,
    output logic aged_o
);

    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] cnt_q;
    logic [AGE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (req_i && !gnt_i) begin
            cnt_d = (cnt_q == {AGE_W{1'b1}}) ? cnt_q : cnt_q + AGE_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign aged_o = (cnt_q >= LIMIT);

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Arbitrates the single register-file write port between the
//               ALU, memory load unit and mul/div unit. One registered grant
//               per cycle; fixed priority MEM > MULDIV > ALU. The source
//               granted in the current cycle is masked from the next decision
//               so its still-asserted req cannot cause a second write.
// Ports       : Clk, Rst_n (async active-low)
//               alu/mem/md_req, alu/mem/md_rd  - requests and dest registers
//               alu/mem/md_gnt                 - one-cycle grant pulses
//               wb_sel   - mux select (01 ALU, 00 MEM, 10 MD, 11 idle)
//               rf_we    - write enable (low for rd == x0)
//               rf_waddr - write address (holds when idle)
//               alu_stall- ALU req pending and not granted
// Config      : `define WB_ARB_AGE_EN enables per-requester wait counters;
//               aged requesters outrank non-aged ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int AGE_LIMIT = 4,
    parameter int AGE_W     = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              md_req,
    input  logic [ADDR_W-1:0] md_rd,
    output logic              alu_gnt,
    output logic              mem_gnt,
    output logic              md_gnt,
    output logic [1:0]        wb_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              alu_stall
);

    if (AGE_W < $clog2(AGE_LIMIT + 1)) begin : g_cfg_check
        $error("wb_port_arbiter: AGE_W too narrow to hold AGE_LIMIT");
    end

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q,   gnt_d;
    logic [1:0]          sel_q,   sel_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;

    logic [NUM_REQ-1:0]  req_w;
    logic [NUM_REQ-1:0]  elig_w;
    logic [NUM_REQ-1:0]  win_w;

    assign req_w[REQ_ALU] = alu_req;
    assign req_w[REQ_MEM] = mem_req;
    assign req_w[REQ_MD]  = md_req;

    // The source being written this cycle still holds req; exclude it.
    assign elig_w = req_w & ~gnt_q;

`ifdef WB_ARB_AGE_EN
    logic [NUM_REQ-1:0] aged_w;
    logic [NUM_REQ-1:0] aged_elig_w;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        wb_age_counter #(
            .AGE_LIMIT (AGE_LIMIT),
            .AGE_W     (AGE_W)
        ) u_age (
            .Clk    (Clk),
            .Rst_n  (Rst_n),
            .req_i  (req_w[i]),
            .gnt_i  (gnt_q[i]),
            .aged_o (aged_w[i])
        );
    end

    // Aged requesters form a higher tier; fixed order breaks ties within it.
    assign aged_elig_w = elig_w & aged_w;
    assign win_w = (|aged_elig_w) ? pick_fixed(aged_elig_w) : pick_fixed(elig_w);
`else
    assign win_w = pick_fixed(elig_w);
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        sel_d   = SEL_NONE;
        we_d    = 1'b0;
        waddr_d = waddr_q;

        // Both states re-arbitrate every cycle; GRANT only means the
        // registered outputs currently carry a write.
        unique case (state_q)
            IDLE:    state_d = (|win_w) ? GRANT : IDLE;
            GRANT:   state_d = (|win_w) ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase

        if (win_w[REQ_MEM]) begin
            sel_d   = SEL_MEM;
            waddr_d = mem_rd;
        end else if (win_w[REQ_MD]) begin
            sel_d   = SEL_MD;
            waddr_d = md_rd;
        end else if (win_w[REQ_ALU]) begin
            sel_d   = SEL_ALU;
            waddr_d = alu_rd;
        end

        if (|win_w) begin
            gnt_d = win_w;
            // x0 is hardwired zero: the source retires but nothing is written.
            we_d  = |waddr_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= SEL_NONE;
            we_q    <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
        end
    end

    assign alu_gnt   = gnt_q[REQ_ALU];
    assign mem_gnt   = gnt_q[REQ_MEM];
    assign md_gnt    = gnt_q[REQ_MD];
    assign wb_sel    = sel_q;
    assign rf_we     = we_q;
    assign rf_waddr  = waddr_q;
    // Gated by reset so the stall is low while the block is held in reset.
    assign alu_stall = Rst_n & alu_req & ~gnt_q[REQ_ALU];

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed scenarios
//               plus randomized protocol-following traffic compared against
//               a behavioural model (priority list + wait-cycle counts).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    localparam int AW        = 5;
    localparam int AGE_LIM   = 4;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          alu_req = 1'b0, mem_req = 1'b0, md_req = 1'b0;
    logic [AW-1:0] alu_rd = '0, mem_rd = '0, md_rd = '0;
    logic          alu_gnt, mem_gnt, md_gnt;
    logic [1:0]    wb_sel;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic          alu_stall;

    int n_checks = 0;
    int n_pass   = 0;

    wb_port_arbiter #(.ADDR_W(AW), .AGE_LIMIT(AGE_LIM), .AGE_W(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .alu_req(alu_req), .alu_rd(alu_rd),
        .mem_req(mem_req), .mem_rd(mem_rd),
        .md_req(md_req),   .md_rd(md_rd),
        .alu_gnt(alu_gnt), .mem_gnt(mem_gnt), .md_gnt(md_gnt),
        .wb_sel(wb_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .alu_stall(alu_stall)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        alu_req = 1'b0; mem_req = 1'b0; md_req = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] g;
        @(negedge Clk);
        Rst_n = 1'b0;
        alu_req = 1'b1; alu_rd = 5'd1;
        mem_req = 1'b1; mem_rd = 5'd2;
        md_req  = 1'b1; md_rd  = 5'd3;
        @(negedge Clk);
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b000 || wb_sel !== 2'b11 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || alu_stall !== 1'b0)
            $display("FAIL reset_state: gnt=%b sel=%b we=%b waddr=%0d stall=%b, want 000/11/0/0/0",
                     g, wb_sel, rf_we, rf_waddr, alu_stall);
        else n_pass++;
        Rst_n = 1'b1;
        @(negedge Clk);
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b010 || wb_sel !== 2'b00 || rf_we !== 1'b1 || rf_waddr !== 5'd2 || alu_stall !== 1'b1)
            $display("FAIL reset_first_grant: gnt=%b sel=%b we=%b waddr=%0d stall=%b, want 010/00/1/2/1",
                     g, wb_sel, rf_we, rf_waddr, alu_stall);
        else n_pass++;
    endtask

    task automatic test_single_alu();
        logic [2:0] g;
        do_reset();
        alu_req = 1'b1; alu_rd = 5'd7;
        @(negedge Clk);
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b001 || wb_sel !== 2'b01 || rf_we !== 1'b1 || rf_waddr !== 5'd7 || alu_stall !== 1'b0)
            $display("FAIL single_alu_grant: gnt=%b sel=%b we=%b waddr=%0d stall=%b, want 001/01/1/7/0",
                     g, wb_sel, rf_we, rf_waddr, alu_stall);
        else n_pass++;
        @(negedge Clk);
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b000 || wb_sel !== 2'b11 || rf_we !== 1'b0 || rf_waddr !== 5'd7 || alu_stall !== 1'b1)
            $display("FAIL single_alu_gap: gnt=%b sel=%b we=%b waddr=%0d stall=%b, want 000/11/0/7/1",
                     g, wb_sel, rf_we, rf_waddr, alu_stall);
        else n_pass++;
        alu_req = 1'b0;
    endtask

    task automatic test_contention();
        logic [2:0] g;
        do_reset();
        mem_req = 1'b1; mem_rd = 5'd3;
        md_req  = 1'b1; md_rd  = 5'd4;
        alu_req = 1'b1; alu_rd = 5'd5;
        @(negedge Clk);
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b010 || wb_sel !== 2'b00 || rf_waddr !== 5'd3 || alu_stall !== 1'b1)
            $display("FAIL contention_mem: gnt=%b sel=%b waddr=%0d stall=%b, want 010/00/3/1",
                     g, wb_sel, rf_waddr, alu_stall);
        else n_pass++;
        @(negedge Clk);
        mem_req = 1'b0;
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b100 || wb_sel !== 2'b10 || rf_waddr !== 5'd4 || alu_stall !== 1'b1)
            $display("FAIL contention_md: gnt=%b sel=%b waddr=%0d stall=%b, want 100/10/4/1",
                     g, wb_sel, rf_waddr, alu_stall);
        else n_pass++;
        @(negedge Clk);
        md_req = 1'b0;
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b001 || wb_sel !== 2'b01 || rf_waddr !== 5'd5 || rf_we !== 1'b1 || alu_stall !== 1'b0)
            $display("FAIL contention_alu: gnt=%b sel=%b waddr=%0d we=%b stall=%b, want 001/01/5/1/0",
                     g, wb_sel, rf_waddr, rf_we, alu_stall);
        else n_pass++;
        @(negedge Clk);
        alu_req = 1'b0;
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b000 || wb_sel !== 2'b11 || rf_we !== 1'b0)
            $display("FAIL contention_idle: gnt=%b sel=%b we=%b, want 000/11/0", g, wb_sel, rf_we);
        else n_pass++;
    endtask

    task automatic test_x0();
        logic [2:0] g;
        do_reset();
        md_req = 1'b1; md_rd = 5'd0;
        @(negedge Clk);
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b100 || wb_sel !== 2'b10 || rf_we !== 1'b0 || rf_waddr !== 5'd0)
            $display("FAIL x0_write: gnt=%b sel=%b we=%b waddr=%0d, want 100/10/0/0",
                     g, wb_sel, rf_we, rf_waddr);
        else n_pass++;
        @(negedge Clk);
        md_req = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        logic [2:0] g;
        do_reset();
        alu_req = 1'b1; alu_rd = 5'd9;
        @(negedge Clk);
        n_checks++;
        if (alu_gnt !== 1'b1 || rf_we !== 1'b1)
            $display("FAIL midrst_pre: alu_gnt=%b we=%b, want 1/1", alu_gnt, rf_we);
        else n_pass++;
        #1 Rst_n = 1'b0;
        #1;
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b000 || rf_we !== 1'b0 || wb_sel !== 2'b11 || rf_waddr !== 5'd0)
            $display("FAIL midrst_async_drop: gnt=%b we=%b sel=%b waddr=%0d, want 000/0/11/0",
                     g, rf_we, wb_sel, rf_waddr);
        else n_pass++;
        alu_req = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        g = {md_gnt, mem_gnt, alu_gnt};
        n_checks++;
        if (g !== 3'b000 || rf_we !== 1'b0)
            $display("FAIL midrst_after_release: gnt=%b we=%b, want 000/0", g, rf_we);
        else n_pass++;
    endtask

    // ALU competes with continuous MEM/MD traffic (grants alternate MEM, MD).
    task automatic test_age();
        int first_alu;
        logic [2:0] g;
        do_reset();
        first_alu = 0;
        mem_req = 1'b1; mem_rd = 5'd1;
        md_req  = 1'b1; md_rd  = 5'd2;
        alu_req = 1'b1; alu_rd = 5'd3;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            g = {md_gnt, mem_gnt, alu_gnt};
            n_checks++;
            if (g !== 3'b001 && g !== 3'b010 && g !== 3'b100)
                $display("FAIL age_onehot: cycle %0d gnt=%b, want exactly one grant", c, g);
            else n_pass++;
            if (alu_gnt === 1'b1 && first_alu == 0) first_alu = c;
        end
        n_checks++;
`ifdef WB_ARB_AGE_EN
        if (first_alu < 1 || first_alu > AGE_LIM + 2)
            $display("FAIL age_alu_bound: first alu_gnt at cycle %0d, want 1..%0d", first_alu, AGE_LIM + 2);
        else n_pass++;
`else
        if (first_alu != 0)
            $display("FAIL age_alu_starve: alu_gnt at cycle %0d, want none under fixed priority", first_alu);
        else n_pass++;
`endif
        alu_req = 1'b0; mem_req = 1'b0; md_req = 1'b0;
    endtask

    // Randomized traffic vs. model: each requester raises req with a random rd,
    // holds until granted and through the grant cycle, then picks anew.
    task automatic test_random();
        int          cur;            // source written this cycle, -1 none
        int          nxt;
        int          waitc [3];
        bit          pending [3];
        logic        rq [3];
        logic [AW-1:0] rdv [3];
        logic [AW-1:0] exp_waddr;
        int          prio [3];
        logic [2:0]  g, eg;
        logic [1:0]  esel;
        int          errs;
        prio[0] = 1; prio[1] = 2; prio[2] = 0;   // MEM, MD, ALU (0=ALU,1=MEM,2=MD)
        do_reset();
        cur = -1; exp_waddr = '0;
        for (int i = 0; i < 3; i++) begin
            waitc[i] = 0; pending[i] = 0; rq[i] = 1'b0; rdv[i] = '0;
        end
        errs = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) begin
                @(negedge Clk);
                g  = {md_gnt, mem_gnt, alu_gnt};
                eg = (cur >= 0) ? (3'b001 << cur) : 3'b000;
                esel = (cur == 0) ? 2'b01 : (cur == 1) ? 2'b00 : (cur == 2) ? 2'b10 : 2'b11;
                n_checks++;
                if (g !== eg || wb_sel !== esel || rf_waddr !== exp_waddr
                    || rf_we !== (cur >= 0 && exp_waddr != 0)
                    || alu_stall !== (rq[0] && cur != 0)) begin
                    if (errs < 10)
                        $display("FAIL random_cycle%0d: gnt=%b sel=%b waddr=%0d we=%b stall=%b, want %b/%b/%0d/%b/%b",
                                 cyc, g, wb_sel, rf_waddr, rf_we, alu_stall, eg, esel, exp_waddr,
                                 (cur >= 0 && exp_waddr != 0), (rq[0] && cur != 0));
                    errs++;
                end else n_pass++;
            end
            for (int i = 0; i < 3; i++) begin
                if (cur == i) pending[i] = 0;
                else if (!pending[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rq[i] = 1'b1; rdv[i] = AW'($urandom_range(0, 31)); pending[i] = 1;
                    end else rq[i] = 1'b0;
                end
            end
            alu_req = rq[0]; alu_rd = rdv[0];
            mem_req = rq[1]; mem_rd = rdv[1];
            md_req  = rq[2]; md_rd  = rdv[2];
            nxt = -1;
`ifdef WB_ARB_AGE_EN
            for (int k = 0; k < 3; k++)
                if (nxt < 0 && rq[prio[k]] && cur != prio[k] && waitc[prio[k]] >= AGE_LIM)
                    nxt = prio[k];
`endif
            for (int k = 0; k < 3; k++)
                if (nxt < 0 && rq[prio[k]] && cur != prio[k]) nxt = prio[k];
            for (int i = 0; i < 3; i++)
                waitc[i] = (rq[i] && cur != i) ? ((waitc[i] < 7) ? waitc[i] + 1 : 7) : 0;
            if (nxt >= 0) exp_waddr = rdv[nxt];
            cur = nxt;
        end
        alu_req = 1'b0; mem_req = 1'b0; md_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_x0();
        test_reset_mid_grant();
        test_age();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three result sources: ALU, memory load unit and multi-cycle mul/div unit.
- Drives the 2-bit select of the 32-bit 3-to-1 writeback mux, plus the register-file write enable and write address.
- Grants one source per cycle. Stalls the ALU pipeline when its writeback is not granted.
- Sits between the EX/MEM/MULDIV result stages and the register file.

Parameters:
- ADDR_W, 5, register-file address width.
- AGE_LIMIT, 4, wait cycles before a requester gets promoted. Used only with WB_ARB_AGE_EN.
- AGE_W, 3, width of each wait counter. Must hold AGE_LIMIT.

Ports:
- Clk  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- alu_req  input  1  ALU result pending. Held until alu_gnt.
- alu_rd  input  ADDR_W  ALU destination register.
- mem_req  input  1  load result pending. Held until mem_gnt.
- mem_rd  input  ADDR_W  load destination register.
- md_req  input  1  mul/div result pending. Held until md_gnt.
- md_rd  input  ADDR_W  mul/div destination register.
- alu_gnt, mem_gnt, md_gnt  output  1 each  one-cycle grant pulse; write occurs this cycle.
- wb_sel  output  2  mux select: 01=ALU (inA), 00=MEM (inB), 10=MULDIV (inC), 11=zero/idle.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  ADDR_W  register-file write address.
- alu_stall  output  1  alu_req pending and not granted this cycle.

Behaviour:
- Reset (async, Rst_n=0):
  - all gnt=0, wb_sel=2'b11, rf_we=0, rf_waddr=0, alu_stall=0.
  - FSM returns to IDLE; wait counters are cleared.
  - A grant in flight when reset asserts is dropped; no write occurs.
- FSM states:
  - IDLE: no grant registered. Any eligible request -> GRANT, else stay.
  - GRANT: registered outputs are live. Re-arbitrate the same cycle: eligible request -> GRANT, else -> IDLE.
- Latency:
  - Request sampled at edge N; gnt/wb_sel/rf_we/rf_waddr are registered and valid in cycle N+1 (one cycle).
  - The requester holds data and rd stable through the grant cycle and drops or renews req at N+2.
- Eligibility:
  - A requester granted in the current cycle is masked from the decision made in that cycle. This prevents a double write from a still-asserted req.
  - Consequence: the same source cannot be granted in consecutive cycles. Minimum one gap cycle.
- Priority (default): fixed, MEM > MULDIV > ALU.
- Outputs in a grant cycle:
  - exactly one gnt is high; wb_sel holds the matching code; rf_waddr = the sampled rd.
  - No grant: wb_sel=2'b11, rf_we=0, rf_waddr holds its previous value.
- Register x0: a grant with rd=0 still pulses gnt (the source retires) but rf_we=0. wb_sel still shows the source code.
- alu_stall is combinational: alu_req & ~alu_gnt.
- Simultaneous requests: only the winner is granted; the losers keep req asserted and are re-evaluated next cycle.
- A req deasserted before grant is legal; the arbiter makes no claim on it.
- The one-hot invariant on {alu_gnt, mem_gnt, md_gnt} must hold every cycle.

Optional Feature:
- Macro: WB_ARB_AGE_EN.
- Defined:
  - Each requester has a saturating wait counter. It increments each cycle the requester has req high but no gnt, and clears on grant or when req is low.
  - A requester whose counter is >= AGE_LIMIT outranks all non-aged requesters.
  - Ties among aged requesters use the fixed order.
  - Bound: ALU worst-case wait is AGE_LIMIT+2 cycles.
- Undefined: no counters; pure fixed priority. ALU may starve under continuous MEM/MULDIV traffic.

Decomposition:
- Package wb_arb_pkg holds:
  - wb_sel codes: SEL_ALU=2'b01, SEL_MEM=2'b00, SEL_MD=2'b10, SEL_NONE=2'b11.
  - FSM state enum: IDLE, GRANT.
  - Requester index constants.
- Sub-module wb_age_counter: one per requester, instantiated only under WB_ARB_AGE_EN. Inputs req, gnt; output aged flag.

Test Plan:
- Reset: hold Rst_n=0 with all reqs high -> wb_sel=11, rf_we=0, no gnt. Release -> first grant is mem_gnt one cycle later.
- Single ALU write: alu_req=1, alu_rd=7 for one edge -> next cycle alu_gnt=1, wb_sel=01, rf_we=1, rf_waddr=7. Following cycle: no grant even though req is still high.
- Three-way contention: mem(rd=3), md(rd=4), alu(rd=5) all held -> grant order MEM, MD, ALU on consecutive cycles. alu_stall is high until the ALU grant.
- x0 write: md_req with md_rd=0 -> md_gnt=1, wb_sel=10, rf_we=0.
- Reset mid-grant: assert Rst_n=0 during a grant cycle -> gnt and rf_we drop immediately (async). No write after release until a new request is sampled.
- WB_ARB_AGE_EN, AGE_LIMIT=4, with ALU competing:
  - Setup: alternate mem_req/md_req continuously while alu_req stays high.
  - Required: alu_gnt arrives within 6 cycles.
  - Without the macro: alu_gnt never arrives during that traffic.
